// File: rtl/capture_pkg.sv
// Shared types and defaults for the logic-analyzer capture sequencer.
package capture_pkg;
  localparam int DEF_DATAW = 32;
  localparam int DEF_CNTW  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;
endpackage

// File: rtl/capture_trig_match.sv
// Masked pattern compare: hit when every enabled bit equals the pattern.
module capture_trig_match #(
  parameter int DATAW = 32
) (
  input  logic [DATAW-1:0] i_sample,
  input  logic [DATAW-1:0] i_mask,
  input  logic [DATAW-1:0] i_value,
  output logic             o_hit
);
  assign o_hit = ~|((i_sample ^ i_value) & i_mask);
endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: arm, wait for masked trigger, push decimated samples to
// the sample FIFO as single-cycle AXI-Stream beats, report run status.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DATAW = DEF_DATAW,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic             slave_clk,
  input  logic             reset,
  input  logic [DATAW-1:0] sample_in,
  input  logic             cfg_arm,
  input  logic             cfg_abort,
  input  logic [DATAW-1:0] cfg_trig_mask,
  input  logic [DATAW-1:0] cfg_trig_value,
  input  logic [CNTW-1:0]  cfg_post_count,
  input  logic [CNTW-1:0]  cfg_decim,
  output logic [DATAW-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             st_busy,
  output logic             st_triggered,
  output logic             st_done,
  output logic             st_overflow,
  output logic [CNTW-1:0]  st_count
);
  cap_state_e       r_state, w_state_nxt;
  logic [DATAW-1:0] r_mask, r_value, r_tdata;
  logic [CNTW-1:0]  r_post, r_decim, r_dcnt, r_count;
  logic             r_tvalid, r_trig, r_done, r_ovf;

  logic             w_hit, w_strobe, w_trig_set, w_done_set, w_last;
  logic [CNTW-1:0]  w_cnt_inc;

  capture_trig_match #(.DATAW(DATAW)) u_trig (
    .i_sample (sample_in),
    .i_mask   (r_mask),
    .i_value  (r_value),
    .o_hit    (w_hit)
  );

  assign w_cnt_inc = r_count + CNTW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_strobe    = 1'b0;
    w_trig_set  = 1'b0;
    w_done_set  = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ARMED: begin
        if (w_hit) begin
          w_trig_set = 1'b1;
          if (r_post == '0) begin
            w_state_nxt = DONE;
            w_done_set  = 1'b1;
          end else begin
            w_strobe    = 1'b1;
            w_state_nxt = CAPTURE;
          end
        end
      end
      CAPTURE: w_strobe = (r_dcnt == '0);
      default: ;
    endcase
    // The strobe that reaches post_count also finishes the run; with
    // post_count = 1 this is the trigger strobe itself.
    if (w_strobe && (w_cnt_inc == r_post)) begin
      w_last      = 1'b1;
      w_state_nxt = DONE;
      w_done_set  = 1'b1;
    end
    if (cfg_abort && (r_state == ARMED || r_state == CAPTURE)) begin
      w_state_nxt = IDLE;
      w_strobe    = 1'b0;
      w_trig_set  = 1'b0;
      w_done_set  = 1'b0;
      w_last      = 1'b0;
    end
    if (cfg_arm) begin
      w_state_nxt = ARMED;
      w_strobe    = 1'b0;
      w_trig_set  = 1'b0;
      w_done_set  = 1'b0;
      w_last      = 1'b0;
    end
  end

  always_ff @(posedge slave_clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mask   <= '0;
      r_value  <= '0;
      r_post   <= '0;
      r_decim  <= '0;
      r_dcnt   <= '0;
      r_count  <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_trig   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tvalid <= w_strobe;
      if (w_strobe) r_tdata <= sample_in;

      if (w_strobe)                               r_dcnt <= r_decim;
      else if (r_state == CAPTURE && r_dcnt != '0) r_dcnt <= r_dcnt - CNTW'(1);

      if (cfg_arm) begin
        r_mask  <= cfg_trig_mask;
        r_value <= cfg_trig_value;
        r_post  <= cfg_post_count;
        r_decim <= cfg_decim;
        r_count <= '0;
        r_trig  <= 1'b0;
        r_done  <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_trig_set) r_trig <= 1'b1;
        if (w_done_set) r_done <= 1'b1;
        if (w_strobe)   r_count <= w_cnt_inc;
        // No stalling: a beat not taken in its only valid cycle is lost.
        if (r_tvalid && !m_tready) r_ovf <= 1'b1;
      end
    end
  end

  assign m_tdata      = r_tdata;
  assign m_tvalid     = r_tvalid;
  assign st_busy      = (r_state == ARMED) || (r_state == CAPTURE);
  assign st_triggered = r_trig;
  assign st_done      = r_done;
  assign st_overflow  = r_ovf;
  assign st_count     = r_count;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed per-cycle vectors for capture_ctrl: each step drives inputs, lets
// one edge pass, then compares beat and status outputs to hand-computed values.
module tb_capture_ctrl;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          slave_clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          cfg_arm = 1'b0, cfg_abort = 1'b0;
  logic [DW-1:0] cfg_trig_mask = '0, cfg_trig_value = '0;
  logic [CW-1:0] cfg_post_count = '0, cfg_decim = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          st_busy, st_triggered, st_done, st_overflow;
  logic [CW-1:0] st_count;

  capture_ctrl #(.DATAW(DW), .CNTW(CW)) dut (
    .slave_clk(slave_clk), .reset(reset), .sample_in(sample_in),
    .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
    .cfg_trig_mask(cfg_trig_mask), .cfg_trig_value(cfg_trig_value),
    .cfg_post_count(cfg_post_count), .cfg_decim(cfg_decim),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .st_busy(st_busy), .st_triggered(st_triggered), .st_done(st_done),
    .st_overflow(st_overflow), .st_count(st_count)
  );

  always #5 slave_clk = ~slave_clk;

  typedef struct {
    logic          rst, arm, abt;
    logic [DW-1:0] smp;
    logic          rdy;
    logic          vld;
    logic [DW-1:0] dat;
    logic          busy, trg, done, ovf;
    logic [CW-1:0] cnt;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;  // free-running count of beats written into the FIFO

  always @(posedge slave_clk) if (m_tvalid && m_tready) n_acc <= n_acc + 1;

  function automatic vec_t v(input logic rst, input logic arm, input logic abt,
                             input logic [DW-1:0] smp, input logic rdy,
                             input logic vld, input logic [DW-1:0] dat,
                             input logic busy, input logic trg, input logic done,
                             input logic ovf, input logic [CW-1:0] cnt);
    vec_t r;
    r.rst = rst; r.arm = arm; r.abt = abt; r.smp = smp; r.rdy = rdy;
    r.vld = vld; r.dat = dat; r.busy = busy; r.trg = trg; r.done = done;
    r.ovf = ovf; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // status packing: {tvalid, busy, triggered, done, overflow, count}
  task automatic step(input vec_t e, input string nm);
    reset = e.rst; cfg_arm = e.arm; cfg_abort = e.abt;
    sample_in = e.smp; m_tready = e.rdy;
    @(posedge slave_clk); #1;
    chk({nm, ".status"}, 64'({m_tvalid, st_busy, st_triggered, st_done, st_overflow, st_count}),
        64'({e.vld, e.busy, e.trg, e.done, e.ovf, e.cnt}));
    if (e.vld) chk({nm, ".tdata"}, 64'(m_tdata), 64'(e.dat));
  endtask

  task automatic set_cfg(input logic [DW-1:0] mask, input logic [DW-1:0] val,
                         input logic [CW-1:0] post, input logic [CW-1:0] decim);
    cfg_trig_mask = mask; cfg_trig_value = val;
    cfg_post_count = post; cfg_decim = decim;
  endtask

  vec_t t1[9];
  int   acc0;

  initial begin
    // Test 1 vectors: mask FF, value 5A, post 4, decim 0, always ready
    t1[0] = v(0, 1, 0, 'h00, 1, 0, 'h00, 1, 0, 0, 0, 0);
    t1[1] = v(0, 0, 0, 'h58, 1, 0, 'h00, 1, 0, 0, 0, 0);
    t1[2] = v(0, 0, 0, 'h59, 1, 0, 'h00, 1, 0, 0, 0, 0);
    t1[3] = v(0, 0, 0, 'h5A, 1, 1, 'h5A, 1, 1, 0, 0, 1);
    t1[4] = v(0, 0, 0, 'h5B, 1, 1, 'h5B, 1, 1, 0, 0, 2);
    t1[5] = v(0, 0, 0, 'h5C, 1, 1, 'h5C, 1, 1, 0, 0, 3);
    t1[6] = v(0, 0, 0, 'h5D, 1, 1, 'h5D, 0, 1, 1, 0, 4);
    t1[7] = v(0, 0, 0, 'h5E, 1, 0, 'h00, 0, 1, 1, 0, 4);
    t1[8] = v(0, 0, 0, 'h5F, 1, 0, 'h00, 0, 1, 1, 0, 4);

    // reset state
    step(v(1, 0, 0, 'h5A, 1, 0, 'h0, 0, 0, 0, 0, 0), "rst0");
    step(v(1, 1, 0, 'h5A, 1, 0, 'h0, 0, 0, 0, 0, 0), "rst1");
    chk("rst.tdata", 64'(m_tdata), 64'h0);

    set_cfg('hFF, 'h5A, 4, 0);
    acc0 = n_acc;
    for (int i = 0; i < 9; i++) step(t1[i], $sformatf("t1[%0d]", i));
    chk("t1.written", 64'(n_acc - acc0), 64'd4);

    // decim = 2: strobes on cycles 3, 6, 9, 12 after arm
    set_cfg('hFF, 'h5A, 4, 2);
    step(v(0, 1, 0, 'h00, 1, 0, 'h0, 1, 0, 0, 0, 0), "t2.arm");
    for (int i = 1; i <= 13; i++) begin
      logic       sv;
      logic [CW-1:0] c;
      sv = (i >= 3) && ((i - 3) % 3 == 0);
      c  = (i < 3) ? CW'(0) : (i >= 12 ? CW'(4) : CW'((i - 3) / 3 + 1));
      step(v(0, 0, 0, DW'('h57 + i), 1, sv, DW'('h57 + i), i < 12, i >= 3, i >= 12, 0, c),
           $sformatf("t2[%0d]", i));
    end

    // dropped 2nd beat: overflow sets, count still reaches post_count
    set_cfg('hFF, 'h5A, 3, 0);
    acc0 = n_acc;
    step(v(0, 1, 0, 'h00, 1, 0, 'h00, 1, 0, 0, 0, 0), "t3.arm");
    step(v(0, 0, 0, 'h5A, 1, 1, 'h5A, 1, 1, 0, 0, 1), "t3.b1");
    step(v(0, 0, 0, 'h5B, 1, 1, 'h5B, 1, 1, 0, 0, 2), "t3.b2");
    step(v(0, 0, 0, 'h5C, 0, 1, 'h5C, 0, 1, 1, 1, 3), "t3.b3");
    step(v(0, 0, 0, 'h5D, 1, 0, 'h00, 0, 1, 1, 1, 3), "t3.end");
    chk("t3.written", 64'(n_acc - acc0), 64'd2);

    // post_count = 0: trigger goes straight to DONE with no beat
    set_cfg('hFF, 'h5A, 0, 0);
    step(v(0, 1, 0, 'h00, 1, 0, 'h00, 1, 0, 0, 0, 0), "t4.arm");
    step(v(0, 0, 0, 'h5A, 1, 0, 'h00, 0, 1, 1, 0, 0), "t4.trig");
    step(v(0, 0, 0, 'h5B, 1, 0, 'h00, 0, 1, 1, 0, 0), "t4.hold");

    // mask = 0 triggers on first ARMED cycle; arm wins over abort; abort ignored in DONE
    set_cfg('h0, 'hFFFF_FFFF, 1, 0);
    step(v(0, 1, 1, 'h00, 1, 0, 'h0000, 1, 0, 0, 0, 0), "t5.armabt");
    step(v(0, 0, 0, 'h1234, 1, 1, 'h1234, 0, 1, 1, 0, 1), "t5.trig");
    step(v(0, 0, 1, 'h0, 1, 0, 'h0000, 0, 1, 1, 0, 1), "t5.abtdone");

    // abort after 2 of 8 beats, then re-arm and complete
    set_cfg('hFF, 'h5A, 8, 0);
    step(v(0, 1, 0, 'h00, 1, 0, 'h00, 1, 0, 0, 0, 0), "t6.arm");
    step(v(0, 0, 0, 'h5A, 1, 1, 'h5A, 1, 1, 0, 0, 1), "t6.b1");
    step(v(0, 0, 0, 'h5B, 1, 1, 'h5B, 1, 1, 0, 0, 2), "t6.b2");
    step(v(0, 0, 1, 'h5C, 1, 0, 'h00, 0, 1, 0, 0, 2), "t6.abort");
    step(v(0, 0, 0, 'h5A, 1, 0, 'h00, 0, 1, 0, 0, 2), "t6.idle");
    acc0 = n_acc;
    step(v(0, 1, 0, 'h00, 1, 0, 'h00, 1, 0, 0, 0, 0), "t6.rearm");
    for (int k = 0; k < 10; k++)
      step(v(0, 0, 0, DW'('h5A + k), 1, k < 8, DW'('h5A + k), k < 7, 1, k >= 7, 0,
             (k < 8) ? CW'(k + 1) : CW'(8)), $sformatf("t6[%0d]", k));
    chk("t6.written", 64'(n_acc - acc0), 64'd8);

    // reset in CAPTURE, then a normal short run
    set_cfg('hFF, 'h5A, 8, 0);
    step(v(0, 1, 0, 'h00, 1, 0, 'h00, 1, 0, 0, 0, 0), "t7.arm");
    step(v(0, 0, 0, 'h5A, 1, 1, 'h5A, 1, 1, 0, 0, 1), "t7.b1");
    step(v(0, 0, 0, 'h5B, 1, 1, 'h5B, 1, 1, 0, 0, 2), "t7.b2");
    step(v(1, 0, 0, 'h5C, 1, 0, 'h00, 0, 0, 0, 0, 0), "t7.rst");
    chk("t7.rst.tdata", 64'(m_tdata), 64'h0);
    set_cfg('hFF, 'h5A, 2, 0);
    step(v(0, 1, 0, 'h00, 1, 0, 'h00, 1, 0, 0, 0, 0), "t7.rearm");
    step(v(0, 0, 0, 'h5A, 1, 1, 'h5A, 1, 1, 0, 0, 1), "t7.c1");
    step(v(0, 0, 0, 'h5B, 1, 1, 'h5B, 0, 1, 1, 0, 2), "t7.c2");
    step(v(0, 0, 0, 'h5C, 1, 0, 'h00, 0, 1, 1, 0, 2), "t7.end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
